// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared constants and FSM state type for the cipher stream controller
// Purpose: mode encodings, modulus, character bounds and the controller state enum.
// Ports: none (package).
package cipher_pkg;

    localparam logic [1:0] MODE_ENC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [7:0] P_MOD     = 8'd227;
    localparam logic [7:0] NULL_CHAR = 8'h00;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_Z   = 8'h7A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/char_cipher_core.sv
// rtl/char_cipher_core.sv - combinational mod-227 encrypt/decrypt of one character
// Purpose: computes the ciphered character and flags whether it is legal for the mode.
// Ports:
//   mode_i       [1:0] MODE_ENC / MODE_DEC, anything else yields valid_char_o = 0
//   char_i       [7:0] input character
//   key_i        [7:0] key, assumed < P_MOD
//   result_o     [7:0] processed character
//   valid_char_o       character is legal for the selected mode
module char_cipher_core
    import cipher_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [7:0] char_i,
    input  logic [7:0] key_i,
    output logic [7:0] result_o,
    output logic       valid_char_o
);

    logic [8:0] sum9;

    // Results always land below 227, so 8-bit wrap-around arithmetic is exact
    // once the correct branch is chosen; only the encrypt compare needs 9 bits.
    assign sum9 = {1'b0, char_i} + {1'b0, key_i};

    always_comb begin
        result_o     = char_i;
        valid_char_o = 1'b0;
        case (mode_i)
            MODE_ENC: begin
                valid_char_o = (char_i >= LOWER_A) && (char_i <= LOWER_Z);
                if (sum9 >= {1'b0, P_MOD}) begin
                    result_o = char_i + key_i - P_MOD;
                end else begin
                    result_o = char_i + key_i;
                end
            end
            MODE_DEC: begin
                valid_char_o = (char_i < P_MOD);
                if (char_i >= key_i) begin
                    result_o = char_i - key_i;
                end else begin
                    result_o = char_i + P_MOD - key_i;
                end
            end
            default: begin
                result_o     = char_i;
                valid_char_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cipher_stream_ctrl.sv
// rtl/cipher_stream_ctrl.sv - streaming mod-227 cipher controller with one-entry output register
// Purpose: accepts a null-terminated character stream, encrypts or decrypts each
// character, and reports busy/done/err status and the output character count.
// Build option: CIPHER_CTRL_SKIP_INVALID_EN drops invalid characters and keeps
// running instead of aborting the message.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, mode[1:0], key[7:0]      message start pulse with mode/key sampled on it
//   in_valid, in_ready, in_char     input character handshake
//   out_valid, out_ready, out_char  output character handshake
//   busy, done, err                 status; done/err are single-cycle pulses
//   char_count[7:0]                 non-terminator characters output this message
module cipher_stream_ctrl
    import cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] key,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] char_count
);

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] key_q, key_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_char_q, out_char_d;
    logic [7:0] count_q, count_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       accept;
    logic       consume;
    logic       start_legal;
    logic       overflow;
    logic [7:0] core_result;
    logic       core_valid;

    char_cipher_core u_core (
        .mode_i       (mode_q),
        .char_i       (in_char),
        .key_i        (key_q),
        .result_o     (core_result),
        .valid_char_o (core_valid)
    );

    assign accept      = in_valid && in_ready;
    assign consume     = out_valid_q && out_ready;
    assign start_legal = ((mode == MODE_ENC) || (mode == MODE_DEC)) && (key < P_MOD);
    // In RUN the output register only ever holds a non-terminator, so counted
    // plus pending characters is count_q + out_valid_q; one more must not pass 255.
    assign overflow    = ({1'b0, count_q} + {8'd0, out_valid_q}) >= 9'd255;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 2'b00;
            key_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            count_q     <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            count_q     <= count_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        key_d       = key_q;
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        count_d     = count_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (consume) begin
            out_valid_d = 1'b0;
            if (state_q == ST_RUN) begin
                count_d = count_q + 8'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        state_d = ST_RUN;
                        mode_d  = mode;
                        key_d   = key;
                        count_d = 8'h00;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (in_char == NULL_CHAR) begin
                        out_valid_d = 1'b1;
                        out_char_d  = NULL_CHAR;
                        state_d     = ST_FLUSH;
                    end else if (overflow) begin
                        err_d       = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = ST_ERR;
                    end else if (!core_valid) begin
                        err_d = 1'b1;
`ifdef CIPHER_CTRL_SKIP_INVALID_EN
                        // Dropped: the output register keeps whatever the consume above left.
`else
                        out_valid_d = 1'b0;
                        state_d     = ST_ERR;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        out_char_d  = core_result;
                    end
                end
            end
            ST_FLUSH: begin
                if (consume) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        busy       = (state_q != ST_IDLE);
        out_valid  = out_valid_q;
        out_char   = out_char_q;
        done       = done_q;
        err        = err_q;
        char_count = count_q;
    end

endmodule

// File: doc/cipher_stream_ctrl.md
CIPHER_STREAM_CTRL -- requirements
Module: cipher_stream_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state rising-edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  one-cycle pulse; begins a message when IDLE.
REQ-004 SHALL have: mode  in  2  2'b01 encrypt, 2'b10 decrypt, others illegal; sampled on start.
REQ-005 SHALL have: key  in  8  public key; sampled on start.
REQ-006 SHALL have: in_valid, in_ready  in/out  1 each  input char handshake.
REQ-007 SHALL have: in_char  in  8  input character; 8'h00 terminates the message.
REQ-008 SHALL have: out_valid, out_ready  out/in  1 each  output char handshake.
REQ-009 SHALL have: out_char  out  8  processed character.
REQ-010 SHALL have: busy, done, err  out  1 each  status; done and err are one-cycle pulses.
REQ-011 SHALL have: char_count  out  8  characters output in current/last message, excluding terminator.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FLUSH -> IDLE, plus ERR -> IDLE.
REQ-013 IDLE: start with legal mode and key < 8'd227 latches mode/key, clears char_count, goes RUN; start with illegal mode or key >= 227 pulses err next cycle, stays IDLE.
REQ-014 Transfers SHALL occur when valid && ready on the same rising edge.
REQ-015 in_ready = (state==RUN) && (!out_valid || out_ready); no combinational path from in_valid to in_ready.
REQ-016 Latency: an accepted char appears on out_char with out_valid high the next cycle; one-entry output register.
REQ-017 out_char and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-018 Encrypt: char valid iff 8'h61..8'h7A; out = (P + K) mod 227, computed in 9 bits, subtract 227 once if sum >= 227.
REQ-019 Decrypt: char valid iff P < 227; out = P - K if P >= K, else P + 227 - K.
REQ-020 Accepted 8'h00 SHALL be output as 8'h00 (no arithmetic), then FSM goes FLUSH.
REQ-021 FLUSH: when the terminator is consumed on the output, pulse done for one cycle and go IDLE.
REQ-022 Invalid char (macro off): not output; pulse err, go ERR; ERR drops out_valid, returns IDLE next cycle.
REQ-023 char_count increments per non-terminator output accepted; a 256th character SHALL error per REQ-022 rather than wrap.
REQ-024 start SHALL be ignored outside IDLE; busy = (state != IDLE).
REQ-025 Simultaneous output consume and input accept in one cycle SHALL be supported (full throughput, one char/cycle).

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, out_valid 0, out_char 8'h00, in_ready 0, busy 0, done 0, err 0, char_count 0, latched mode/key 0.
REQ-027 Reset mid-message SHALL discard the in-flight character without a done or err pulse.

Configuration
REQ-028 Macro CIPHER_CTRL_SKIP_INVALID_EN defined: an invalid char is accepted, dropped, not counted, err pulses one cycle, FSM stays RUN.
REQ-029 Undefined: behaviour per REQ-022 (abort message).

Structure
REQ-030 Shared package cipher_pkg SHALL hold MODE_ENC, MODE_DEC, P_MOD = 8'd227, NULL_CHAR = 8'h00, LOWER_A = 8'h61, LOWER_Z = 8'h7A and the FSM state enum.
REQ-031 Modular arithmetic SHALL sit in combinational sub-module char_cipher_core (inputs mode, char, key; outputs result, valid_char).

Verification
REQ-032 Encrypt, key 8'h10: "a",00 -> out 8'h71, 8'h00; done pulse; char_count 1.
REQ-033 Encrypt, key 8'hC8: 'z' (8'h7A) -> 8'h5F (322-227).
REQ-034 Decrypt, key 8'h10: 8'h05 -> 8'hD8; 8'h20 -> 8'h10.
REQ-035 start with key 8'hE3 -> err pulse, busy stays 0; encrypt 'A' (8'h41) -> err, no output, IDLE (macro off) / err, next char processed (macro on).
REQ-036 out_ready low 3 cycles mid-stream -> out_char stable, in_ready 0, no loss or duplication; full rate one char/cycle with out_ready high.
REQ-037 rst_n asserted during RUN with out_valid high -> all outputs at reset values same cycle, no done/err pulse.
